// File: rtl/mem_pkg.sv
// Shared types for the data memory responder.
// FSM states, decode classes and I/O register offsets.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        DEC_RAM,
        DEC_IO_OUT,
        DEC_IO_IN,
        DEC_ERR
    } dec_t;

    localparam logic [31:0] IO_OUT_OFS = 32'd0;
    localparam logic [31:0] IO_IN_OFS  = 32'd4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs.
// Output lags the input by two rising edges.
module sync_2ff #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/data_mem_responder.sv
// Load/store port responder: word RAM plus two-register I/O window,
// req/ack handshake with a fixed number of wait states.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int          DEPTH       = 64,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] IO_BASE     = 32'h0000_0400,
    parameter int          IO_W        = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic            we,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            ack,
    output logic            err,
    input  logic [IO_W-1:0] io_in,
    output logic [IO_W-1:0] io_out
);

    localparam int          AW          = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES   = 32'(DEPTH * 4);
    localparam logic [31:0] IO_OUT_ADDR = IO_BASE + IO_OUT_OFS;
    localparam logic [31:0] IO_IN_ADDR  = IO_BASE + IO_IN_OFS;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q, rdata_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic [IO_W-1:0] io_out_q, io_out_d;
    logic [IO_W-1:0] io_sync;
    logic [31:0]     mem_q [DEPTH];

    dec_t            dec;
    logic            capture;
    logic            commit;
    logic            ram_we;
    logic [AW-1:0]   widx;

    sync_2ff #(
        .W(IO_W)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (io_in),
        .q_o (io_sync)
    );

    // Misalignment wins over every mapped region.
    always_comb begin
        dec = DEC_ERR;
        if (addr_q[1:0] != 2'b00) begin
            dec = DEC_ERR;
        end else if (addr_q < RAM_BYTES) begin
            dec = DEC_RAM;
        end else if (addr_q == IO_OUT_ADDR) begin
            dec = DEC_IO_OUT;
        end else if (addr_q == IO_IN_ADDR) begin
            dec = we_q ? DEC_ERR : DEC_IO_IN;
        end
    end

    assign capture = (state_q == IDLE) && req;
    assign commit  = (state_q == WAIT) && (cnt_q == 4'd0);
    assign ram_we  = commit && we_q && (dec == DEC_RAM);
    assign widx    = addr_q[AW+1:2];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        io_out_d = io_out_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = WAIT;
                    cnt_d   = 4'(WAIT_STATES);
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = RESP;
                    ack_d   = 1'b1;
                    unique case (dec)
                        DEC_RAM: begin
                            if (!we_q) rdata_d = mem_q[widx];
                        end
                        DEC_IO_OUT: begin
                            if (we_q) io_out_d = wdata_q[IO_W-1:0];
                            else      rdata_d  = 32'(io_out_q);
                        end
                        DEC_IO_IN: begin
                            rdata_d = 32'(io_sync);
                        end
                        default: begin
                            rdata_d = '0;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rdata_q  <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            io_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            io_out_q <= io_out_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (capture) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) mem_q[widx] <= wdata_q;
    end

    assign rdata  = rdata_q;
    assign ack    = ack_q;
    assign err    = err_q;
    assign io_out = io_out_q;

endmodule
